// File: rtl/trivium_seq_ctrl.sv
// trivium_seq_ctrl: loads key/IV into a Trivium core, waits for warm-up, then streams host bytes.
// Defining TRV_SEQ_TIMEOUT_EN adds a warm-up watchdog that sets the sticky err flag.
module trivium_seq_ctrl #(
    parameter int KEY_BITS   = 80,
    parameter int IV_BYTES   = 10,
    parameter int WARMUP_MAX = 2048
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key_in,
    input  logic [8*IV_BYTES-1:0] iv_in,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  busy,
    output logic                  err,
    output logic                  KEY,
    output logic                  STB_KEY,
    output logic [7:0]            DATA,
    output logic                  STB_DATA,
    output logic                  READ,
    input  logic [7:0]            DATA_OUT,
    input  logic [7:0]            SIGN_REG
);
    localparam int CW = $clog2(KEY_BITS > IV_BYTES ? KEY_BITS : IV_BYTES);
    localparam logic [CW-1:0] KLAST = CW'(KEY_BITS - 1);
    localparam logic [CW-1:0] ILAST = CW'(IV_BYTES - 1);

    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_IV, WARMUP, STREAM} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [KEY_BITS-1:0]   key_q;
    logic [8*IV_BYTES-1:0] iv_q, iv_sh;
    logic                  rd_q, ov_q;
    logic [7:0]            dout_q;
    logic                  accept, tmo, unused_sign;

    assign accept      = state_q == IDLE && start && !abort;
    assign unused_sign = ^SIGN_REG[7:1];

`ifdef TRV_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(WARMUP_MAX + 1);
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
    assign tmo    = state_q == WARMUP && !SIGN_REG[0] && wcnt_q == WW'(WARMUP_MAX - 1);
    assign wcnt_d = (state_q == WARMUP && !abort && !tmo && !SIGN_REG[0]) ? wcnt_q + 1'b1 : '0;
    assign err_d  = accept ? 1'b0 : (tmo && !abort) ? 1'b1 : err_q;
    assign err    = err_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end
`else
    logic unused_cfg;
    assign tmo        = 1'b0;
    assign err        = 1'b0;
    assign unused_cfg = WARMUP_MAX != 0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = start ? LOAD_KEY : IDLE;
            LOAD_KEY: begin
                cnt_d   = (cnt_q == KLAST) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == KLAST) ? LOAD_IV : LOAD_KEY;
            end
            LOAD_IV: begin
                cnt_d   = (cnt_q == ILAST) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == ILAST) ? WARMUP : LOAD_IV;
            end
            WARMUP: state_d = SIGN_REG[0] ? STREAM : tmo ? IDLE : WARMUP;
            default: ;
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Strobes are gated by abort so they fall in the abort cycle itself.
    assign busy     = state_q != IDLE;
    assign STB_KEY  = state_q == LOAD_KEY && !abort;
    assign STB_DATA = state_q == LOAD_IV && !abort;
    assign in_ready = state_q == STREAM && !abort;
    assign READ     = in_ready && in_valid;
    assign KEY      = STB_KEY && key_q[KLAST - cnt_q];
    assign iv_sh    = iv_q >> {ILAST - cnt_q, 3'b000};
    assign DATA     = STB_DATA ? iv_sh[7:0] : READ ? in_data : 8'h00;
    assign out_valid = ov_q;
    assign out_data  = dout_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            iv_q    <= '0;
            rd_q    <= 1'b0;
            ov_q    <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                key_q <= key_in;
                iv_q  <= iv_in;
            end
            rd_q <= READ;
            ov_q <= rd_q;
            if (rd_q) dout_q <= DATA_OUT;
        end
    end
endmodule

// File: tb/tb_trivium_seq_ctrl.sv
// tb_trivium_seq_ctrl: scoreboard bench for trivium_seq_ctrl with a registered XOR core model.
module tb_trivium_seq_ctrl;
    logic        CLK = 0, RST = 1, start = 0, abort = 0, in_valid = 0;
    logic [79:0] key_in = '0, iv_in = '0;
    logic [7:0]  in_data = '0, DATA_OUT = '0, SIGN_REG = '0;
    logic        in_ready, out_valid, busy, err, KEY, STB_KEY, STB_DATA, READ;
    logic [7:0]  out_data, DATA;
    int          n_tests = 0, n_fail = 0, cyc = 0;
    int          exp_cyc[$];
    logic [7:0]  exp_dat[$];

    trivium_seq_ctrl #(.KEY_BITS(80), .IV_BYTES(10), .WARMUP_MAX(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .key_in(key_in), .iv_in(iv_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .busy(busy), .err(err), .KEY(KEY), .STB_KEY(STB_KEY), .DATA(DATA),
        .STB_DATA(STB_DATA), .READ(READ), .DATA_OUT(DATA_OUT), .SIGN_REG(SIGN_REG)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (READ) DATA_OUT <= DATA ^ 8'hC3;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) chk("onehot", {31'b0, $onehot0({STB_KEY, STB_DATA, READ})}, 1);
        if (out_valid) begin
            if (exp_dat.size() == 0) chk("ov_unexpected", 1, 0);
            else begin
                chk("ov_cycle", exp_cyc.pop_front(), cyc);
                chk("out_data", out_data, exp_dat.pop_front());
            end
        end
    end

    task automatic load(input logic [79:0] k, input logic [79:0] v);
        key_in = k; iv_in = v; start = 1;
        @(negedge CLK); start = 0;
        for (int i = 0; i < 80; i++) begin
            chk("stb_key", STB_KEY, 1);
            chk("key_bit", KEY, k[79-i]);
            chk("no_stb_data", STB_DATA, 0);
            @(negedge CLK);
        end
        for (int i = 0; i < 10; i++) begin
            chk("stb_data", STB_DATA, 1);
            chk("iv_byte", DATA, v[79-8*i -: 8]);
            chk("no_stb_key", STB_KEY, 0);
            @(negedge CLK);
        end
        chk("warmup_strobes", {STB_KEY, STB_DATA, READ}, 0);
        chk("warmup_busy", busy, 1);
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1; in_data = b; #1;
        chk("in_ready", in_ready, 1);
        chk("read", READ, 1);
        chk("data_byte", DATA, b);
        exp_cyc.push_back(cyc + 2);
        exp_dat.push_back(b ^ 8'hC3);
        @(negedge CLK);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_outs", {busy, in_ready, out_valid, out_data, err, KEY, STB_KEY, DATA, STB_DATA, READ}, 0);
        RST = 0;
        @(negedge CLK);
        chk("idle_busy", busy, 0);

        load(80'h0123456789ABCDEF0123, 80'hA5A55A5A0000FFFF1234);
        repeat (3) begin
            chk("wait_not_ready", in_ready, 0);
            @(negedge CLK);
        end
        SIGN_REG = 8'h01; #1;
        chk("ready_before_w", in_ready, 0);
        @(negedge CLK);
        chk("ready_after_w", in_ready, 1);
        send(8'h00); send(8'hFF); send(8'h3C);
        in_valid = 0;
        repeat (3) @(negedge CLK);
        chk("sb_drained", exp_dat.size(), 0);

        start = 1; key_in = '1;
        @(negedge CLK); start = 0;
        chk("ign_start_busy", busy, 1);
        chk("ign_start_strobes", {STB_KEY, STB_DATA}, 0);
        chk("ign_start_ready", in_ready, 1);
        send(8'h81);
        in_valid = 0; abort = 1; #1;
        chk("abort_ready", in_ready, 0);
        @(negedge CLK); abort = 0;
        chk("abort_idle", busy, 0);
        repeat (2) @(negedge CLK);
        chk("inflight_done", exp_dat.size(), 0);

        SIGN_REG = 8'h00;
        key_in = 80'hFEDCBA98765432100F0F; start = 1;
        @(negedge CLK); start = 0;
        repeat (40) @(negedge CLK);
        chk("bit40_stb", STB_KEY, 1);
        abort = 1; #1;
        chk("abort_drop", STB_KEY, 0);
        @(negedge CLK); abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_stb_key", STB_KEY, 0);
        repeat (15) begin
            chk("abort_no_iv", STB_DATA, 0);
            @(negedge CLK);
        end
        start = 1; abort = 1;
        @(negedge CLK); start = 0; abort = 0;
        chk("abort_beats_start", busy, 0);

        load(80'h0F1E2D3C4B5A69788796, 80'h00112233445566778899);
`ifdef TRV_SEQ_TIMEOUT_EN
        repeat (15) begin
            @(negedge CLK);
            chk("tmo_waiting", {busy, err}, 2'b10);
        end
        @(negedge CLK);
        chk("tmo_err", {busy, err}, 2'b01);
        start = 1;
        @(negedge CLK); start = 0;
        chk("tmo_err_clr", {busy, err}, 2'b10);
`else
        repeat (40) @(negedge CLK);
        chk("no_tmo", {busy, err}, 2'b10);
`endif
        abort = 1;
        @(negedge CLK); abort = 0;

        key_in = 80'h1; start = 1;
        @(negedge CLK); start = 0;
        repeat (5) @(negedge CLK);
        RST = 1; #1;
        chk("midrst", {busy, STB_KEY, KEY, err}, 0);
        @(negedge CLK); RST = 0;
        @(negedge CLK);
        chk("midrst_idle", {busy, STB_KEY, STB_DATA}, 0);
        chk("sb_empty", exp_dat.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
